// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// State encoding and default operand width.
package mult_pkg;

  localparam int WL_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mult_dp.sv
// Shift-add datapath: accumulator, shifting operands, step counter.
// Steered by load/step strobes from the controller.
module seq_mult_dp
  import mult_pkg::*;
#(
  parameter int WL = WL_DEF,
  parameter int CW = $clog2(WL + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [WL-1:0]   a,
  input  logic [WL-1:0]   b,
  output logic            last,
  output logic [2*WL-1:0] sum
);

  logic [2*WL-1:0] acc;
  logic [2*WL-1:0] mcand;
  logic [WL-1:0]   mplier;
  logic [CW-1:0]   count;

  // Accumulator value after the current step
  assign sum  = acc + (mplier[0] ? mcand : '0);
  assign last = (count == CW'(WL - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {{WL{1'b0}}, a};
      mplier <= b;
      count  <= '0;
    end else if (step) begin
      acc    <= sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Multi-cycle unsigned multiplier: FSM plus registered outputs.
// One partial product per clock, fixed WL-cycle latency.
module seq_mult_ctrl
  import mult_pkg::*;
#(
  parameter int WL = WL_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [WL-1:0]   a,
  input  logic [WL-1:0]   b,
  output logic            busy,
  output logic            done,
  output logic [2*WL-1:0] product
);

  localparam int CW = $clog2(WL + 1);

  state_t          state, state_n;
  logic            load, step, last;
  logic [2*WL-1:0] sum;

  seq_mult_dp #(.WL(WL), .CW(CW)) u_dp (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .a    (a),
    .b    (b),
    .last (last),
    .sum  (sum)
  );

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_n = ST_CALC;
        end
      end
      ST_CALC: begin
        step = 1'b1;
        if (last) state_n = ST_DONE;
      end
      ST_DONE: begin
        if (start) begin
          load    = 1'b1;
          state_n = ST_CALC;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Flags are registered from the next state so they align with it
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      state <= state_n;
      busy  <= (state_n == ST_CALC);
      done  <= (state_n == ST_DONE);
      if (step && last) product <= sum;
    end
  end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Scoreboard bench for seq_mult_ctrl: WL=4 directed and WL=8 random.
// Drivers queue expected product and done cycle; monitors compare.
module tb_seq_mult_ctrl;

  typedef struct {
    int prod;
    int cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst4 = 1'b1, rst8 = 1'b1;
  logic        start4 = 1'b0, start8 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy4, done4, busy8, done8;
  logic [7:0]  product4;
  logic [15:0] product8;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_acc8 = 0;
  int   n_done8 = 0;
  exp_t q4[$];
  exp_t q8[$];

  seq_mult_ctrl #(.WL(4)) dut4 (
    .clk     (clk),
    .rst     (rst4),
    .start   (start4),
    .a       (a4),
    .b       (b4),
    .busy    (busy4),
    .done    (done4),
    .product (product4)
  );

  seq_mult_ctrl #(.WL(8)) dut8 (
    .clk     (clk),
    .rst     (rst8),
    .start   (start8),
    .a       (a8),
    .b       (b8),
    .busy    (busy8),
    .done    (done8),
    .product (product8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int got, int req);
    n_cmp++;
    if (got != req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)",
               name, got, req, cyc);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (busy4 && done4) chk("busy4_and_done4", 1, 0);
    if (done4) begin
      if (q4.size() == 0) begin
        chk("unexpected_done4", 1, 0);
      end else begin
        e = q4.pop_front();
        chk("product4", int'(product4), e.prod);
        chk("latency4", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (busy8 && done8) chk("busy8_and_done8", 1, 0);
    if (done8) begin
      n_done8++;
      if (q8.size() == 0) begin
        chk("unexpected_done8", 1, 0);
      end else begin
        e = q8.pop_front();
        chk("product8", int'(product8), e.prod);
        chk("latency8", cyc, e.cyc);
      end
    end
  end

  // Called on a negedge; start is sampled at the following posedge
  task automatic issue4(input int a, input int b, input bit acc);
    exp_t e;
    a4 = 4'(a);
    b4 = 4'(b);
    start4 = 1'b1;
    if (acc) begin
      e.prod = a * b;
      e.cyc  = cyc + 1 + 4;
      q4.push_back(e);
    end
    @(negedge clk);
    start4 = 1'b0;
    a4 = 4'($urandom_range(0, 15));
    b4 = 4'($urandom_range(0, 15));
  endtask

  task automatic issue8(input int a, input int b);
    exp_t e;
    a8 = 8'(a);
    b8 = 8'(b);
    start8 = 1'b1;
    e.prod = a * b;
    e.cyc  = cyc + 1 + 8;
    q8.push_back(e);
    n_acc8++;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom_range(0, 255));
    b8 = 8'($urandom_range(0, 255));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst4 = 1'b0;
    rst8 = 1'b0;
    chk("reset_busy", int'(busy4), 0);
    chk("reset_done", int'(done4), 0);
    chk("reset_product", int'(product4), 0);
    @(negedge clk);

    // 15 x 15: busy for four cycles, then done
    issue4(15, 15, 1);
    for (int i = 0; i < 4; i++) begin
      chk("t1_busy_calc", int'(busy4), 1);
      @(negedge clk);
    end
    chk("t1_busy_in_done", int'(busy4), 0);
    @(negedge clk);
    chk("t1_busy_after", int'(busy4), 0);
    chk("t1_done_after", int'(done4), 0);
    chk("t1_product_held", int'(product4), 225);
    repeat (3) @(negedge clk);
    chk("t1_product_held2", int'(product4), 225);

    // zero operands keep the full latency
    issue4(0, 9, 1);
    repeat (6) @(negedge clk);
    issue4(9, 0, 1);
    repeat (6) @(negedge clk);

    // start pulsed during CALC must be ignored
    issue4(13, 11, 1);
    issue4(1, 1, 0);
    repeat (8) @(negedge clk);
    chk("t3_product", int'(product4), 143);

    // back-to-back: second start during the DONE cycle
    issue4(3, 5, 1);
    repeat (4) @(negedge clk);
    chk("t4_done_cycle", int'(done4), 1);
    issue4(7, 6, 1);
    chk("t4_busy_rises", int'(busy4), 1);
    chk("t4_product_stable", int'(product4), 15);
    repeat (5) @(negedge clk);
    chk("t4_product2", int'(product4), 42);

    // reset at the second CALC edge aborts the operation
    issue4(12, 12, 0);
    rst4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    chk("t5_busy_after_rst", int'(busy4), 0);
    chk("t5_product_after_rst", int'(product4), 0);
    repeat (6) @(negedge clk);
    chk("t5_product_still0", int'(product4), 0);
    issue4(2, 3, 1);
    repeat (6) @(negedge clk);
    chk("t5_product", int'(product4), 6);

    // WL=8: corners first, then random pairs and gaps
    issue8(255, 255);
    repeat (8) @(negedge clk);
    issue8(0, 255);
    repeat (8) @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      repeat (8) @(negedge clk);
    end
    repeat (12) @(negedge clk);

    chk("q4_drained", q4.size(), 0);
    chk("q8_drained", q8.size(), 0);
    chk("done8_count", n_done8, n_acc8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
